// File: rtl/voting_machine_param.sv
// Parametrised debounced voting machine: vote FSM, saturating tallies, result display, winner/tie.
// Optional feature macro VOTE_TOTAL_EN adds a registered vote total and a saturation flag.
module voting_machine_param #(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    parameter int DEBOUNCE = 10
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              mode,
    input  logic [NUM_CAND-1:0]               button,
    output logic [CNT_W-1:0]                  led,
    output logic                              vote_valid,
    output logic                              vote_reject,
    output logic [$clog2(NUM_CAND)-1:0]       winner,
    output logic                              tie
`ifdef VOTE_TOTAL_EN
    ,
    output logic [CNT_W+$clog2(NUM_CAND)-1:0] total,
    output logic                              total_full
`endif
);

    localparam int IDX_W = $clog2(NUM_CAND);
    localparam int DBC_W = $clog2(DEBOUNCE + 1);
    localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_WAIT_REL} state_t;

    state_t              state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [DBC_W-1:0]    dbc, dbc_n;
    logic                released;
    logic [CNT_W-1:0]    tally [NUM_CAND];

    logic                btn_any, btn_one, btn_multi, cap_high, others;
    logic [IDX_W-1:0]    low_idx;
    logic                do_vote, do_reject;
    logic [CNT_W-1:0]    max_v, led_c;
    logic [IDX_W-1:0]    win_c;
    logic                tie_c;

    always_comb begin
        low_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--)
            if (button[i]) low_idx = IDX_W'(i);
    end

    assign btn_any   = |button;
    assign btn_one   = btn_any && ((button & (button - NUM_CAND'(1))) == '0);
    assign btn_multi = btn_any && !btn_one;
    assign cap_high  = button[idx];
    assign others    = |(button & ~(NUM_CAND'(1) << idx));

    // released stays low after reset until every button has been seen low once
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            dbc      <= '0;
            released <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            dbc   <= dbc_n;
            if (!btn_any) released <= 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        dbc_n   = dbc;
        if (mode) begin
            state_n = S_WAIT_REL;
            dbc_n   = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (released && btn_one) begin
                        state_n = S_DEBOUNCE;
                        idx_n   = low_idx;
                        dbc_n   = DBC_W'(1);
                    end else if (released && btn_multi) begin
                        state_n = S_WAIT_REL;
                    end
                end
                S_DEBOUNCE: begin
                    if (others || dbc == DBC_LAST) begin
                        state_n = S_WAIT_REL;
                        dbc_n   = '0;
                    end else if (!cap_high) begin
                        state_n = S_IDLE;
                        dbc_n   = '0;
                    end else begin
                        dbc_n = dbc + DBC_W'(1);
                    end
                end
                S_WAIT_REL: begin
                    if (!btn_any) state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_comb begin
        do_vote   = !mode && state == S_DEBOUNCE && !others && cap_high && dbc == DBC_LAST;
        do_reject = !mode && ((state == S_IDLE && released && btn_multi) ||
                              (state == S_DEBOUNCE && others));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) tally[i] <= '0;
            vote_valid  <= 1'b0;
            vote_reject <= 1'b0;
        end else begin
            vote_valid  <= do_vote;
            vote_reject <= do_reject;
            if (do_vote && tally[idx] != '1) tally[idx] <= tally[idx] + CNT_W'(1);
        end
    end

    // lowest index holding the maximum wins; tie needs a second holder and a non-zero max
    always_comb begin
        max_v = tally[0];
        win_c = '0;
        tie_c = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tally[i] > max_v) begin
                max_v = tally[i];
                win_c = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_CAND; i++)
            if (tally[i] == max_v && IDX_W'(i) != win_c) tie_c = 1'b1;
        if (max_v == '0) tie_c = 1'b0;
    end

    assign led_c = (mode && btn_any) ? tally[low_idx] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            led    <= '0;
            winner <= '0;
            tie    <= 1'b0;
        end else begin
            led    <= led_c;
            winner <= win_c;
            tie    <= tie_c;
        end
    end

`ifdef VOTE_TOTAL_EN
    logic [CNT_W+IDX_W-1:0] total_c;
    logic                   full_c;

    always_comb begin
        total_c = '0;
        full_c  = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            total_c = total_c + (CNT_W + IDX_W)'(tally[i]);
            if (tally[i] == '1) full_c = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            total      <= '0;
            total_full <= 1'b0;
        end else begin
            total      <= total_c;
            total_full <= full_c;
        end
    end
`endif

endmodule

// File: tb/tb_voting_machine_param.sv
// Directed bench for voting_machine_param: default instance plus a CNT_W=2 instance for saturation.
module tb_voting_machine_param;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       mode  = 1'b0;
    logic [3:0] button0 = 4'b0;
    logic [3:0] button1 = 4'b0;

    logic [7:0] led0;
    logic [1:0] led1;
    logic       vv0, vr0, vv1, vr1, tie0, tie1;
    logic [1:0] winner0, winner1;
`ifdef VOTE_TOTAL_EN
    logic [9:0] total0;
    logic [3:0] total1;
    logic       full0, full1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    voting_machine_param dut0 (
        .clock(clock), .reset(reset), .mode(mode), .button(button0),
        .led(led0), .vote_valid(vv0), .vote_reject(vr0), .winner(winner0), .tie(tie0)
`ifdef VOTE_TOTAL_EN
        , .total(total0), .total_full(full0)
`endif
    );

    voting_machine_param #(.NUM_CAND(4), .CNT_W(2), .DEBOUNCE(10)) dut1 (
        .clock(clock), .reset(reset), .mode(mode), .button(button1),
        .led(led1), .vote_valid(vv1), .vote_reject(vr1), .winner(winner1), .tie(tie1)
`ifdef VOTE_TOTAL_EN
        , .total(total1), .total_full(full1)
`endif
    );

    task automatic cycle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_button(input bit sel, input logic [3:0] btn);
        if (sel) button1 = btn;
        else     button0 = btn;
    endtask

    // holds the current buttons for n cycles, counting pulses seen at each negedge
    task automatic count_hold(input bit sel, input int n, output int vv_n, output int vr_n);
        vv_n = 0;
        vr_n = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            if (sel ? vv1 : vv0) vv_n++;
            if (sel ? vr1 : vr0) vr_n++;
        end
    endtask

    task automatic apply_stimulus(input bit sel, input logic [3:0] btn, input int hold,
                                  output int vv_n, output int vv_at,
                                  output int vr_n, output int vr_at);
        vv_n = 0; vv_at = 0; vr_n = 0; vr_at = 0;
        set_button(sel, btn);
        for (int k = 1; k <= hold + 3; k++) begin
            if (k == hold + 1) set_button(sel, 4'b0);
            @(negedge clock);
            if (sel ? vv1 : vv0) begin
                vv_n++;
                if (vv_at == 0) vv_at = k;
            end
            if (sel ? vr1 : vr0) begin
                vr_n++;
                if (vr_at == 0) vr_at = k;
            end
        end
    endtask

    task automatic show_led(input bit sel, input logic [3:0] btn, input string tag, input int exp);
        mode = 1'b1;
        set_button(sel, btn);
        cycle(1);
        check_output(tag, sel ? 32'(led1) : 32'(led0), exp);
    endtask

    task automatic back_to_vote();
        button0 = 4'b0;
        button1 = 4'b0;
        mode    = 1'b0;
        cycle(2);
    endtask

    initial begin
        int vn, va, rn, ra, sum;

        $display("[TB] reset");
        cycle(2);
        check_output("reset_led", led0, 0);
        check_output("reset_vv", vv0, 0);
        check_output("reset_vr", vr0, 0);
        check_output("reset_winner", winner0, 0);
        check_output("reset_tie", tie0, 0);
        reset = 1'b0;
        cycle(2);

        $display("[TB] T1 single vote");
        apply_stimulus(0, 4'b0001, 15, vn, va, rn, ra);
        check_output("t1_vv_count", vn, 1);
        check_output("t1_vv_cycle", va, 10);
        check_output("t1_vr_count", rn, 0);
        button0 = 4'b0001;
        cycle(1);
        check_output("t1_led_vote_mode", led0, 0);
        button0 = 4'b0;
        cycle(2);
        show_led(0, 4'b0001, "t1_tally0", 1);
        show_led(0, 4'b0000, "t1_led_nobutton", 0);
        back_to_vote();

        $display("[TB] T2 short press");
        apply_stimulus(0, 4'b0010, 5, vn, va, rn, ra);
        check_output("t2_vv_count", vn, 0);
        check_output("t2_vr_count", rn, 0);

        $display("[TB] T3 multi press");
        apply_stimulus(0, 4'b0101, 5, vn, va, rn, ra);
        check_output("t3_vr_count", rn, 1);
        check_output("t3_vr_cycle", ra, 1);
        check_output("t3_vv_count", vn, 0);

        $display("[TB] T4 hold and repeat");
        apply_stimulus(0, 4'b0010, 40, vn, va, rn, ra);
        check_output("t4_hold_vv_count", vn, 1);
        sum = 0;
        for (int p = 0; p < 3; p++) begin
            apply_stimulus(0, 4'b0010, 15, vn, va, rn, ra);
            sum += vn;
        end
        check_output("t4_repeat_vv_total", sum, 3);
        check_output("t4_winner", winner0, 1);
        check_output("t4_tie", tie0, 0);
        show_led(0, 4'b0010, "t4_tally1", 4);
        show_led(0, 4'b0011, "t4_lowest_pressed", 1);
        show_led(0, 4'b0100, "t4_tally2", 0);
        show_led(0, 4'b0001, "t4_tally0", 1);
`ifdef VOTE_TOTAL_EN
        check_output("t4_total", total0, 5);
`endif
        back_to_vote();

        $display("[TB] T5 result and tie");
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        cycle(2);
        for (int p = 0; p < 3; p++) apply_stimulus(0, 4'b0001, 12, vn, va, rn, ra);
        for (int p = 0; p < 2; p++) apply_stimulus(0, 4'b0100, 12, vn, va, rn, ra);
        check_output("t5_pre_tie", tie0, 0);
        apply_stimulus(0, 4'b0100, 12, vn, va, rn, ra);
        check_output("t5_tie", tie0, 1);
        check_output("t5_winner", winner0, 0);
        show_led(0, 4'b0100, "t5_tally2", 3);
        check_output("t5_tie_result_mode", tie0, 1);
        show_led(0, 4'b0000, "t5_led_nobutton", 0);
`ifdef VOTE_TOTAL_EN
        check_output("t5_total", total0, 6);
        check_output("t5_total_full", full0, 0);
`endif
        back_to_vote();

        $display("[TB] reset mid-debounce");
        button0 = 4'b0001;
        cycle(5);
        reset = 1'b1;
        cycle(1);
        check_output("rst_tie_cleared", tie0, 0);
        reset = 1'b0;
        count_hold(0, 15, vn, rn);
        check_output("rst_held_no_vote", vn, 0);
        button0 = 4'b0;
        cycle(2);
        apply_stimulus(0, 4'b0001, 12, vn, va, rn, ra);
        check_output("rst_after_release_vote", vn, 1);
        show_led(0, 4'b0001, "rst_tally0", 1);
        back_to_vote();

        $display("[TB] T6 saturation and abort");
        reset = 1'b1;
        cycle(1);
        reset = 1'b0;
        cycle(2);
        sum = 0;
        for (int p = 0; p < 4; p++) begin
            apply_stimulus(1, 4'b0001, 12, vn, va, rn, ra);
            sum += vn;
        end
        check_output("t6_sat_vv_total", sum, 4);
        show_led(1, 4'b0001, "t6_sat_tally", 3);
`ifdef VOTE_TOTAL_EN
        check_output("t6_total", total1, 3);
        check_output("t6_total_full", full1, 1);
`endif
        back_to_vote();
        button1 = 4'b0010;
        cycle(5);
        mode = 1'b1;
        cycle(1);
        mode = 1'b0;
        count_hold(1, 15, vn, rn);
        check_output("t6_abort_no_vote", vn, 0);
        check_output("t6_abort_no_reject", rn, 0);
        button1 = 4'b0;
        cycle(2);
        show_led(1, 4'b0010, "t6_abort_tally1", 0);
        back_to_vote();
        apply_stimulus(1, 4'b0010, 12, vn, va, rn, ra);
        check_output("t6_vote_after_abort", vn, 1);
        show_led(1, 4'b0010, "t6_tally1", 1);
        check_output("t6_winner", winner1, 0);
        check_output("t6_tie", tie1, 0);
        back_to_vote();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
